// File: rtl/output_layer_pkg.sv
// Shared constants, FSM state type and score arithmetic helpers for the output-layer back end.
// sat_add is only referenced when SCORE_SAT_EN is defined.
package output_layer_pkg;

    localparam int NUM_OUT = 10;
    localparam int PROD_W  = 16;
    localparam int ACC_W   = 24;
    localparam int BIAS_W  = 8;
    localparam int IDX_W   = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ACCUM = 3'd1,
        BIAS  = 3'd2,
        SCAN  = 3'd3,
        DONE  = 3'd4
    } state_t;

    // Sign-magnitude bias to two's complement; a negative zero maps to 0.
    function automatic logic signed [ACC_W-1:0] sm2tc(input logic [BIAS_W-1:0] b);
        logic signed [ACC_W-1:0] mag;
        mag = ACC_W'(b[BIAS_W-2:0]);
        return b[BIAS_W-1] ? -mag : mag;
    endfunction

    function automatic logic signed [ACC_W-1:0] sat_add(input logic signed [ACC_W-1:0] a,
                                                        input logic signed [ACC_W-1:0] b);
        logic signed [ACC_W:0] sum;
        sum = {a[ACC_W-1], a} + {b[ACC_W-1], b};
        if (sum[ACC_W] != sum[ACC_W-1])
            return sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        return sum[ACC_W-1:0];
    endfunction

endpackage

// File: rtl/score_argmax.sv
// Sequential argmax scan over the score register file: one strict signed compare per step,
// so ties keep the lowest index.
module score_argmax
    import output_layer_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    init,
    input  logic                    step,
    input  logic signed [ACC_W-1:0] first_score,
    input  logic signed [ACC_W-1:0] cur_score,
    output logic [IDX_W-1:0]        k,
    output logic [IDX_W-1:0]        best_idx,
    output logic signed [ACC_W-1:0] best,
    output logic                    last
);

    assign last = (k == IDX_W'(NUM_OUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k        <= '0;
            best_idx <= '0;
            best     <= '0;
        end else if (init) begin
            best     <= first_score;
            best_idx <= '0;
            k        <= IDX_W'(1);
        end else if (step) begin
            if (cur_score > best) begin
                best     <= cur_score;
                best_idx <= k;
            end
            k <= k + IDX_W'(1);
        end
    end

endmodule

// File: rtl/output_score_argmax.sv
// Output-layer back end: per-neuron product accumulation, bias add, then argmax scan.
// Define SCORE_SAT_EN to saturate accumulator and bias add instead of wrapping.
module output_score_argmax
    import output_layer_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_OUT*BIAS_W-1:0]   bias_in,
    input  logic                        start,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic signed [PROD_W-1:0]    in_data,
    input  logic                        in_last,
    output logic                        class_valid,
    input  logic                        class_ready,
    output logic [IDX_W-1:0]            class_idx,
    output logic signed [ACC_W-1:0]     class_score,
    output logic                        busy
);

    function automatic logic signed [ACC_W-1:0] add_score(input logic signed [ACC_W-1:0] a,
                                                          input logic signed [ACC_W-1:0] b);
`ifdef SCORE_SAT_EN
        return sat_add(a, b);
`else
        return a + b;
`endif
    endfunction

    state_t                  state, state_next;
    logic [IDX_W-1:0]        n;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] score [NUM_OUT];

    logic                    beat;
    logic                    last_neuron;
    logic                    scan_init;
    logic                    scan_step;
    logic                    scan_last;
    logic [IDX_W-1:0]        scan_k;
    logic signed [ACC_W-1:0] cur_score;

    assign beat        = in_valid & in_ready;
    assign last_neuron = (n == IDX_W'(NUM_OUT - 1));
    assign cur_score   = (scan_k < IDX_W'(NUM_OUT)) ? score[scan_k] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next  = state;
        in_ready    = 1'b0;
        class_valid = 1'b0;
        busy        = (state != IDLE);
        scan_init   = 1'b0;
        scan_step   = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_next = ACCUM;
            end
            ACCUM: begin
                in_ready = 1'b1;
                if (beat && in_last) state_next = BIAS;
            end
            BIAS: begin
                if (last_neuron) begin
                    scan_init  = 1'b1;
                    state_next = SCAN;
                end else begin
                    state_next = ACCUM;
                end
            end
            SCAN: begin
                scan_step = 1'b1;
                if (scan_last) state_next = DONE;
            end
            DONE: begin
                class_valid = 1'b1;
                if (class_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Accumulator, neuron counter and score register file.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            n   <= '0;
            for (int i = 0; i < NUM_OUT; i++) score[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        acc <= '0;
                        n   <= '0;
                    end
                end
                ACCUM: begin
                    if (beat) acc <= add_score(acc, ACC_W'(in_data));
                end
                BIAS: begin
                    score[n] <= add_score(acc, sm2tc(bias_in[n*BIAS_W +: BIAS_W]));
                    acc      <= '0;
                    if (!last_neuron) n <= n + IDX_W'(1);
                end
                default: ;
            endcase
        end
    end

    score_argmax u_argmax (
        .clk         (clk),
        .rst_n       (rst_n),
        .init        (scan_init),
        .step        (scan_step),
        .first_score (score[0]),
        .cur_score   (cur_score),
        .k           (scan_k),
        .best_idx    (class_idx),
        .best        (class_score),
        .last        (scan_last)
    );

endmodule

// File: tb/tb_output_score_argmax.sv
// Randomized self-checking bench for output_score_argmax with an arithmetic reference model;
// honours SCORE_SAT_EN the same way as the design.
module tb_output_score_argmax;
    import output_layer_pkg::*;

    logic                      clk = 1'b0;
    logic                      rst_n = 1'b0;
    logic [NUM_OUT*BIAS_W-1:0] bias_in = '0;
    logic                      start = 1'b0;
    logic                      in_valid = 1'b0;
    logic                      in_ready;
    logic signed [PROD_W-1:0]  in_data = '0;
    logic                      in_last = 1'b0;
    logic                      class_valid;
    logic                      class_ready = 1'b0;
    logic [IDX_W-1:0]          class_idx;
    logic signed [ACC_W-1:0]   class_score;
    logic                      busy;

    int total = 0;
    int bad   = 0;

    int          beats    [NUM_OUT][$];
    logic [7:0]  bias_raw [NUM_OUT];

    always #5 clk = ~clk;

    output_score_argmax dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bias_in     (bias_in),
        .start       (start),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_last     (in_last),
        .class_valid (class_valid),
        .class_ready (class_ready),
        .class_idx   (class_idx),
        .class_score (class_score),
        .busy        (busy)
    );

    function automatic logic [7:0] enc(input int v);
        int m;
        m = (v < 0) ? -v : v;
        return {(v < 0) ? 1'b1 : 1'b0, 7'(m)};
    endfunction

    function automatic longint dec(input logic [7:0] b);
        longint m;
        m = longint'(b[6:0]);
        return b[7] ? -m : m;
    endfunction

    // Reduce an exact sum to the score range, either clamped or taken modulo 2^24.
    function automatic longint fit(input longint v);
        longint m;
`ifdef SCORE_SAT_EN
        if (v > 64'sd8388607)  return 64'sd8388607;
        if (v < -64'sd8388608) return -64'sd8388608;
        return v;
`else
        m = v % 64'sd16777216;
        if (m < 0) m += 64'sd16777216;
        if (m >= 64'sd8388608) m -= 64'sd16777216;
        return m;
`endif
    endfunction

    function automatic longint model_score(input int k);
        longint a;
        a = 0;
        foreach (beats[k][j]) a = fit(a + beats[k][j]);
        return fit(a + dec(bias_raw[k]));
    endfunction

    task automatic clear_beats();
        for (int i = 0; i < NUM_OUT; i++) beats[i].delete();
    endtask

    task automatic load_scenario1();
        int b [NUM_OUT] = '{-3, -46, 35, 2, 21, 3, -31, -70, 86, 7};
        clear_beats();
        for (int i = 0; i < NUM_OUT; i++) begin
            bias_raw[i] = enc(b[i]);
            beats[i].push_back(0);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input string name, input int data, input logic last, output logic ok);
        logic rdy;
        int   guard;
        in_data  = PROD_W'(data);
        in_last  = last;
        in_valid = 1'b1;
        guard    = 0;
        do begin
            rdy = in_ready;
            step();
            guard++;
        end while (!rdy && guard < 20);
        in_valid = 1'b0;
        in_last  = 1'b0;
        ok = rdy;
        if (!rdy) begin
            total++; bad++;
            $display("FAIL %s beat_accept got=timeout want=accepted", name);
        end
    endtask

    // hold < 0: class_ready raised before class_valid; otherwise class_ready held low for hold cycles.
    task automatic run_inference(input string name, input int gap_pct, input int hold);
        longint                  s [NUM_OUT];
        longint                  best;
        int                      best_i;
        int                      lat;
        logic                    ok;
        logic [IDX_W-1:0]        want_idx;
        logic signed [ACC_W-1:0] want_score;

        for (int i = 0; i < NUM_OUT; i++) begin
            s[i] = model_score(i);
            bias_in[i*BIAS_W +: BIAS_W] = bias_raw[i];
        end
        best = s[0]; best_i = 0;
        for (int i = 1; i < NUM_OUT; i++) if (s[i] > best) begin best = s[i]; best_i = i; end
        want_idx   = IDX_W'(best_i);
        want_score = ACC_W'(best);

        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < NUM_OUT; k++) begin
            for (int j = 0; j < beats[k].size(); j++) begin
                send_beat(name, beats[k][j], (j == beats[k].size() - 1), ok);
                if (!ok) return;
                if (!(k == NUM_OUT - 1 && j == beats[k].size() - 1) && $urandom_range(99) < gap_pct)
                    step();
            end
        end

        if (hold < 0) class_ready = 1'b1;
        lat = 0;
        while (!class_valid && lat < 40) begin
            step();
            lat++;
        end
        total++;
        if (lat != NUM_OUT) begin
            bad++;
            $display("FAIL %s latency got=%0d want=%0d", name, lat, NUM_OUT);
        end
        total++;
        if (class_idx !== want_idx) begin
            bad++;
            $display("FAIL %s class_idx got=%0d want=%0d", name, class_idx, want_idx);
        end
        total++;
        if (class_score !== want_score) begin
            bad++;
            $display("FAIL %s class_score got=%0d want=%0d", name, class_score, want_score);
        end

        for (int c = 0; c < hold; c++) begin
            start = (c % 2 == 0);
            step();
            total++;
            if (class_valid !== 1'b1 || busy !== 1'b1 || class_idx !== want_idx || class_score !== want_score) begin
                bad++;
                $display("FAIL %s hold_stable cyc=%0d got=v%b b%b %0d/%0d want=v1 b1 %0d/%0d",
                         name, c, class_valid, busy, class_idx, class_score, want_idx, want_score);
            end
        end
        start = 1'b0;

        class_ready = 1'b1;
        step();
        class_ready = 1'b0;
        total++;
        if (class_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL %s handshake_idle got=v%b b%b r%b want=v0 b0 r0", name, class_valid, busy, in_ready);
        end
    endtask

    task automatic check_reset_values(input string name);
        total++;
        if (in_ready !== 1'b0 || class_valid !== 1'b0 || class_idx !== '0 || class_score !== '0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL %s reset_outputs got=r%b v%b %0d/%0d b%b want=r0 v0 0/0 b0",
                     name, in_ready, class_valid, class_idx, class_score, busy);
        end
    endtask

    task automatic test_reset();
        #2;
        check_reset_values("reset");
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check_reset_values("reset_release");
    endtask

    task automatic test_basic();
        load_scenario1();
        in_valid = 1'b1;
        in_data  = 16'sd1234;
        for (int c = 0; c < 2; c++) begin
            step();
            total++;
            if (in_ready !== 1'b0 || busy !== 1'b0) begin
                bad++;
                $display("FAIL idle_ignore got=r%b b%b want=r0 b0", in_ready, busy);
            end
        end
        in_valid = 1'b0;
        run_inference("basic", 0, 0);
    endtask

    task automatic test_tie();
        load_scenario1();
        beats[2][0] = 51;
        run_inference("tie", 0, 0);
    endtask

    task automatic test_toggle_valid();
        load_scenario1();
        beats[0].delete();
        beats[0].push_back(100);
        beats[0].push_back(-20);
        beats[0].push_back(5);
        run_inference("toggle_82", 100, 0);
        beats[0].delete();
        beats[0].push_back(90);
        run_inference("toggle_87", 100, -1);
    endtask

    task automatic test_saturation();
        load_scenario1();
        beats[4].delete();
        for (int i = 0; i < 300; i++) beats[4].push_back(32767);
        run_inference("sat_wrap", 0, 0);
    endtask

    task automatic test_back_to_back();
        load_scenario1();
        run_inference("hold_a", 0, 5);
        beats[3][0] = 100;
        run_inference("hold_b", 0, 1);
    endtask

    task automatic test_reset_abort();
        logic ok;
        load_scenario1();
        beats[7][0] = 500;
        for (int i = 0; i < NUM_OUT; i++) bias_in[i*BIAS_W +: BIAS_W] = bias_raw[i];
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 5; k++) send_beat("abort", 300, 1'b1, ok);
        send_beat("abort", 300, 1'b0, ok);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("abort");
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check_reset_values("abort_release");
        load_scenario1();
        run_inference("after_abort", 0, 0);
    endtask

    task automatic test_random();
        for (int r = 0; r < 6; r++) begin
            clear_beats();
            for (int i = 0; i < NUM_OUT; i++) begin
                bias_raw[i] = 8'($urandom_range(255));
                for (int j = 0; j < int'($urandom_range(1, 4)); j++)
                    beats[i].push_back(int'($urandom_range(65535)) - 32768);
            end
            if (r == 0) bias_raw[3] = 8'h80;
            run_inference($sformatf("random%0d", r), 30, int'($urandom_range(4)) - 1);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_tie();
        test_toggle_valid();
        test_saturation();
        test_back_to_back();
        test_reset_abort();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
